// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter and its
// shadow matcher.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] PAT_1001    = 4'b1001;
    localparam int         PAT_LEN_DEF = 4;

    localparam int WIDTH_DEF = 16;
    localparam int LEN_W_DEF = 5;
    localparam int CNT_W_DEF = 8;

    // A job length is usable when it names at least one bit and fits the word.
    function automatic logic len_ok(input int len, input int width);
        return (len >= 1) && (len <= width);
    endfunction

endpackage

// File: rtl/seq_shadow_match.sv
// Overlapping pattern matcher: keeps the last PAT_LEN-1 accepted bits and
// flags, one clock later, every accepted bit that completes PATTERN.
// The fill counter suppresses matches until a full history has been seen,
// so a cleared history can never masquerade as real zeros on the line.
module seq_shadow_match
    import seq_pkg::*;
#(
    parameter int                 PAT_LEN = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_1001
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic bit_in,
    input  logic bit_vld,
    output logic match
);

    localparam int HW = PAT_LEN - 1;
    localparam int CW = $clog2(PAT_LEN);

    logic [HW-1:0]      r_hist;
    logic [CW-1:0]      r_fill;
    logic [HW-1:0]      w_hist_base;
    logic [CW-1:0]      w_fill_base;
    logic [PAT_LEN-1:0] w_window;
    logic               w_full;

    // Clear takes effect before the incoming bit so a new job starts fresh.
    always_comb begin
        w_hist_base = clr ? '0 : r_hist;
        w_fill_base = clr ? '0 : r_fill;
        w_window    = {w_hist_base, bit_in};
        w_full      = (w_fill_base == CW'(HW));
    end

    // History, fill level and registered match flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            match  <= 1'b0;
        end else begin
            match <= bit_vld && w_full && (w_window == PATTERN);
            if (bit_vld) begin
                r_hist <= w_window[HW-1:0];
                r_fill <= w_full ? w_fill_base : w_fill_base + CW'(1);
            end else begin
                r_hist <= w_hist_base;
                r_fill <= w_fill_base;
            end
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures a word, its length and a repeat
// count, streams the bits MSB-first one per clock, and flags each bit that
// closes an overlapping PATTERN occurrence as a golden reference.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int                 WIDTH   = WIDTH_DEF,
    parameter int                 LEN_W   = LEN_W_DEF,
    parameter int                 CNT_W   = CNT_W_DEF,
    parameter int                 PAT_LEN = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_1001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [CNT_W-1:0] load_rpt,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             exp_match,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_word;
    logic [LEN_W-1:0] r_len_m1;
    logic [LEN_W-1:0] r_idx;
    logic [CNT_W-1:0] r_rpt;

    logic             w_len_ok;
    logic [LEN_W-1:0] w_ld_len_m1;
    logic             w_last;
    logic             w_cap;
    logic             w_clr;
    logic             w_bit_nxt;
    logic             w_vld_nxt;
    logic [LEN_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0] w_rpt_nxt;

    // Bit select with an index that may be wider than the word needs.
    function automatic logic bit_at(input logic [WIDTH-1:0] word,
                                    input logic [LEN_W-1:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (LEN_W'(i) == idx) r = word[i];
        end
        return r;
    endfunction

    assign load_ready  = (r_state == IDLE);
    assign w_len_ok    = len_ok(int'(load_len), WIDTH);
    assign w_ld_len_m1 = load_len - LEN_W'(1);
    assign w_last      = (r_idx == '0) && (r_rpt == '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; abort only matters while shifting.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (load_valid) w_state_nxt = w_len_ok ? SHIFT : DONE;
            SHIFT:   if (abort) w_state_nxt = IDLE;
                     else if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output/datapath decode: the bit to present next cycle and pointer moves.
    always_comb begin
        w_cap     = 1'b0;
        w_clr     = 1'b0;
        w_bit_nxt = 1'b0;
        w_vld_nxt = 1'b0;
        w_idx_nxt = r_idx;
        w_rpt_nxt = r_rpt;
        unique case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_cap = 1'b1;
                    w_clr = 1'b1;
                    if (w_len_ok) begin
                        w_vld_nxt = 1'b1;
                        w_bit_nxt = bit_at(load_data, w_ld_len_m1);
                        w_idx_nxt = w_ld_len_m1;
                        w_rpt_nxt = load_rpt;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_clr = 1'b1;
                end else if (!w_last) begin
                    w_vld_nxt = 1'b1;
                    if (r_idx == '0) begin
                        w_idx_nxt = r_len_m1;
                        w_rpt_nxt = r_rpt - CNT_W'(1);
                        w_bit_nxt = bit_at(r_word, r_len_m1);
                    end else begin
                        w_idx_nxt = r_idx - LEN_W'(1);
                        w_bit_nxt = bit_at(r_word, r_idx - LEN_W'(1));
                    end
                end
            end
            default: ;
        endcase
    end

    // Job capture, shift pointer, repeat counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word    <= '0;
            r_len_m1  <= '0;
            r_idx     <= '0;
            r_rpt     <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (w_cap) begin
                r_word   <= load_data;
                r_len_m1 <= w_ld_len_m1;
            end
            r_idx     <= w_idx_nxt;
            r_rpt     <= w_rpt_nxt;
            ser_out   <= w_bit_nxt;
            ser_valid <= w_vld_nxt;
            busy      <= (w_state_nxt != IDLE);
            done      <= (w_state_nxt == DONE);
        end
    end

    seq_shadow_match #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_match (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_clr),
        .bit_in  (w_bit_nxt),
        .bit_vld (w_vld_nxt),
        .match   (exp_match)
    );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: a table of jobs with hand-written bit
// streams and match masks, plus abort and mid-stream reset sequences.
module tb_seq_pattern_tx;

    localparam int WIDTH = 16;
    localparam int LEN_W = 5;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] load_data = '0;
    logic [LEN_W-1:0] load_len = '0;
    logic [CNT_W-1:0] load_rpt = '0;
    logic             abort = 1'b0;
    logic             ser_out, ser_valid, exp_match, busy, done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] data;
        logic [LEN_W-1:0] len;
        logic [CNT_W-1:0] rpt;
        bit               ab_acc;
        string            bits;
        string            mt;
    } vec_t;

    vec_t tbl [8];

    seq_pattern_tx dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_rpt   (load_rpt),
        .abort      (abort),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .exp_match  (exp_match),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Load one job, then check every cycle of its stream, the done cycle
    // and the return to idle.
    task automatic run_job(input vec_t v);
        int n;
        n = v.bits.len();
        @(negedge clk);
        chk({v.name, " ready"}, 32'(load_ready), 1);
        load_valid = 1'b1;
        load_data  = v.data;
        load_len   = v.len;
        load_rpt   = v.rpt;
        abort      = v.ab_acc;
        @(posedge clk); #1;
        load_valid = 1'b0;
        abort      = 1'b0;
        load_data  = '0;
        load_len   = 5'd2;
        load_rpt   = '0;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s vld[%0d]", v.name, k), 32'(ser_valid), 1);
            chk($sformatf("%s out[%0d]", v.name, k), 32'(ser_out), 32'(v.bits[k] == "1"));
            chk($sformatf("%s mt[%0d]", v.name, k), 32'(exp_match), 32'(v.mt[k] == "1"));
            chk($sformatf("%s busy[%0d]", v.name, k), 32'(busy), 1);
            chk($sformatf("%s done[%0d]", v.name, k), 32'(done), 0);
            @(posedge clk); #1;
        end
        chk({v.name, " done pulse"}, 32'(done), 1);
        chk({v.name, " vld off"}, 32'(ser_valid), 0);
        chk({v.name, " mt off"}, 32'(exp_match), 0);
        chk({v.name, " busy in done"}, 32'(busy), 1);
        chk({v.name, " not ready in done"}, 32'(load_ready), 0);
        @(posedge clk); #1;
        chk({v.name, " done low"}, 32'(done), 0);
        chk({v.name, " idle busy"}, 32'(busy), 0);
        chk({v.name, " ready back"}, 32'(load_ready), 1);
    endtask

    initial begin
        tbl[0] = '{"p1001",   16'hFFF9, 5'd4,  8'd0, 1'b0, "1001",             "0001"};
        tbl[1] = '{"p7ovl",   16'h0049, 5'd7,  8'd0, 1'b0, "1001001",          "0001001"};
        tbl[2] = '{"p100x3",  16'h0004, 5'd3,  8'd2, 1'b1, "100100100",        "000100100"};
        tbl[3] = '{"len0",    16'hFFFF, 5'd0,  8'd3, 1'b0, "",                 ""};
        tbl[4] = '{"len17",   16'hFFFF, 5'd17, 8'd0, 1'b0, "",                 ""};
        tbl[5] = '{"len1x4",  16'h0001, 5'd1,  8'd3, 1'b0, "1111",             "0000"};
        tbl[6] = '{"p10x2",   16'h0002, 5'd2,  8'd1, 1'b0, "1010",             "0000"};
        tbl[7] = '{"p16",     16'h9249, 5'd16, 8'd0, 1'b0, "1001001001001001", "0001001001001001"};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", 32'(load_ready), 1);
        chk("rst vld", 32'(ser_valid), 0);
        chk("rst out", 32'(ser_out), 0);
        chk("rst mt", 32'(exp_match), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;

        // Abort while idle is ignored
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        chk("idle abort ready", 32'(load_ready), 1);
        chk("idle abort busy", 32'(busy), 0);

        for (int i = 0; i < 8; i++) run_job(tbl[i]);

        // Abort at bit 3 of a len=8 job whose prefix 100 would fake a match
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 16'h0080;
        load_len   = 5'd8;
        load_rpt   = 8'd0;
        @(posedge clk); #1;
        load_valid = 1'b0;
        chk("ab bit1", 32'(ser_out), 1);
        @(posedge clk); #1;
        chk("ab bit2", 32'(ser_out), 0);
        @(posedge clk); #1;
        chk("ab bit3", 32'(ser_out), 0);
        chk("ab bit3 vld", 32'(ser_valid), 1);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab vld", 32'(ser_valid), 0);
        chk("ab busy", 32'(busy), 0);
        chk("ab mt", 32'(exp_match), 0);
        chk("ab done", 32'(done), 0);
        chk("ab ready", 32'(load_ready), 1);
        @(posedge clk); #1;
        chk("ab no late done", 32'(done), 0);
        run_job(tbl[0]);

        // Asynchronous reset in the middle of a long stream
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        load_len   = 5'd16;
        load_rpt   = 8'd5;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("mid vld before rst", 32'(ser_valid), 1);
        reset = 1'b1;
        #1;
        chk("arst ready", 32'(load_ready), 1);
        chk("arst vld", 32'(ser_valid), 0);
        chk("arst out", 32'(ser_out), 0);
        chk("arst busy", 32'(busy), 0);
        chk("arst done", 32'(done), 0);
        chk("arst mt", 32'(exp_match), 0);
        @(negedge clk);
        reset = 1'b0;
        run_job(tbl[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
